// File: rtl/vrb_pkg.sv
// Shared types, constants and helpers for the VRB command/response bus.
package vrb_pkg;

    localparam int unsigned VRB_DW = 32;
    localparam int unsigned VRB_MW = VRB_DW / 8;

    // Legal write-mask encodings: single bytes, aligned halfwords, full word.
    localparam logic [VRB_MW-1:0] WM_B0 = 4'h1;
    localparam logic [VRB_MW-1:0] WM_B1 = 4'h2;
    localparam logic [VRB_MW-1:0] WM_B2 = 4'h4;
    localparam logic [VRB_MW-1:0] WM_B3 = 4'h8;
    localparam logic [VRB_MW-1:0] WM_H0 = 4'h3;
    localparam logic [VRB_MW-1:0] WM_H1 = 4'hC;
    localparam logic [VRB_MW-1:0] WM_W  = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } vrb_state_e;

    // True when the write mask is a legal shape for the given low address bits.
    function automatic logic vrb_mask_ok(input logic [1:0] lsb, input logic [VRB_MW-1:0] wmask);
        logic ok;
        case (wmask)
            WM_B0, WM_B1, WM_B2, WM_B3: ok = 1'b1;
            WM_H0, WM_H1:               ok = ~lsb[0];
            WM_W:                       ok = (lsb == 2'b00);
            default:                    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/vrb_sram.sv
// Single-port word RAM with byte-lane write enables and a registered read port.
// The read register returns zero on any cycle without a read strobe, so it can
// feed a response bus that must be quiet between transfers.
module vrb_sram
    import vrb_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    localparam int unsigned IW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IW-1:0]     addr,
    input  logic              we,
    input  logic [VRB_MW-1:0] wmask,
    input  logic [VRB_DW-1:0] wdata,
    input  logic              re,
    output logic [VRB_DW-1:0] rdata
);

    logic [VRB_DW-1:0] mem [DEPTH];

    // Byte-lane write port; array contents are never reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < int'(VRB_MW); b++) begin
            if (we && wmask[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // Registered read, forced to zero when no read is requested.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end else begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/vrb_ram_slave.sv
// VRB responder backed by a byte-maskable word RAM. Captures one command,
// optionally waits LATENCY cycles, then strobes a single-cycle response.
module vrb_ram_slave
    import vrb_pkg::*;
#(
    parameter int unsigned   AW        = 32,
    parameter int unsigned   DW        = VRB_DW,
    parameter logic [AW-1:0] BASE_ADDR = AW'(32'h2000_0000),
    parameter int unsigned   DEPTH     = 1024,
    parameter int unsigned   LATENCY   = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_vrb_cmd_valid,
    input  logic [AW-1:0]   i_vrb_cmd_addr,
    input  logic            i_vrb_cmd_read,
    input  logic [DW-1:0]   i_vrb_cmd_wdata,
    input  logic [DW/8-1:0] i_vrb_cmd_wmask,
    output logic            o_vrb_rsp_valid,
    output logic            o_vrb_rsp_err,
    output logic [DW-1:0]   o_vrb_rsp_rdata
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned MW = DW / 8;
    localparam int unsigned CW = 4;
    localparam logic [AW:0] SPAN = (AW+1)'(DEPTH) << 2;
    localparam logic HAS_WAIT = (LATENCY != 0);

    vrb_state_e     state, next_state;
    logic [CW-1:0]  cnt, cnt_next;
    logic           capture;

    logic [IW-1:0]  cap_idx;
    logic           cap_read;
    logic [DW-1:0]  cap_wdata;
    logic [MW-1:0]  cap_wmask;
    logic           cap_err;

    logic [AW-1:0]  offset;
    logic           in_range;
    logic [IW-1:0]  in_idx;
    logic           in_err;

    logic [IW-1:0]  sel_idx;
    logic           sel_read;
    logic [DW-1:0]  sel_wdata;
    logic [MW-1:0]  sel_wmask;
    logic           sel_err;
    logic           go_resp;
    logic           ram_we;
    logic           ram_re;

    logic           rsp_valid;
    logic           rsp_err;
    logic [DW-1:0]  ram_rdata;

    // Address decode and error decision for the command on the bus.
    always_comb begin
        offset   = i_vrb_cmd_addr - BASE_ADDR;
        in_range = ({1'b0, offset} < SPAN);
        in_idx   = offset[IW+1:2];
        in_err   = ~in_range | (~i_vrb_cmd_read & ~vrb_mask_ok(i_vrb_cmd_addr[1:0], i_vrb_cmd_wmask));
    end

    // Next-state, wait counter and capture control.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (i_vrb_cmd_valid) begin
                    capture = 1'b1;
                    if (HAS_WAIT) begin
                        next_state = WAIT;
                        cnt_next   = CW'(LATENCY);
                    end else begin
                        next_state = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt == CW'(1)) begin
                    next_state = RESP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // With zero latency the RAM access happens on the capture edge itself,
    // so the live bus fields stand in for the not-yet-loaded capture regs.
    always_comb begin
        if (state == IDLE) begin
            sel_idx   = in_idx;
            sel_read  = i_vrb_cmd_read;
            sel_wdata = i_vrb_cmd_wdata;
            sel_wmask = i_vrb_cmd_wmask;
            sel_err   = in_err;
        end else begin
            sel_idx   = cap_idx;
            sel_read  = cap_read;
            sel_wdata = cap_wdata;
            sel_wmask = cap_wmask;
            sel_err   = cap_err;
        end
        go_resp = (next_state == RESP);
        ram_we  = go_resp & ~sel_read & ~sel_err;
        ram_re  = go_resp &  sel_read & ~sel_err;
    end

    // State and wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    // Command capture; dropped by reset so a pending write never commits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_idx   <= '0;
            cap_read  <= 1'b0;
            cap_wdata <= '0;
            cap_wmask <= '0;
            cap_err   <= 1'b0;
        end else if (capture) begin
            cap_idx   <= in_idx;
            cap_read  <= i_vrb_cmd_read;
            cap_wdata <= i_vrb_cmd_wdata;
            cap_wmask <= i_vrb_cmd_wmask;
            cap_err   <= in_err;
        end
    end

    // Response strobe and error qualifier, high only during RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= go_resp;
            rsp_err   <= go_resp & sel_err;
        end
    end

    vrb_sram #(
        .DEPTH (DEPTH)
    ) u_sram (
        .clk   (clk),
        .rst   (rst),
        .addr  (sel_idx),
        .we    (ram_we),
        .wmask (sel_wmask),
        .wdata (sel_wdata),
        .re    (ram_re),
        .rdata (ram_rdata)
    );

    assign o_vrb_rsp_valid = rsp_valid;
    assign o_vrb_rsp_err   = rsp_err;
    assign o_vrb_rsp_rdata = ram_rdata;

endmodule

// File: tb/tb_vrb_ram_slave.sv
// Directed bench for vrb_ram_slave: one instance with LATENCY=0, one with 3.
module tb_vrb_ram_slave;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        cmd_valid [2];
    logic [31:0] cmd_addr  [2];
    logic        cmd_read  [2];
    logic [31:0] cmd_wdata [2];
    logic [3:0]  cmd_wmask [2];
    logic        rsp_valid [2];
    logic        rsp_err   [2];
    logic [31:0] rsp_rdata [2];

    vrb_ram_slave #(.LATENCY(0)) u_lat0 (
        .clk(clk), .rst(rst),
        .i_vrb_cmd_valid(cmd_valid[0]), .i_vrb_cmd_addr(cmd_addr[0]),
        .i_vrb_cmd_read(cmd_read[0]), .i_vrb_cmd_wdata(cmd_wdata[0]),
        .i_vrb_cmd_wmask(cmd_wmask[0]),
        .o_vrb_rsp_valid(rsp_valid[0]), .o_vrb_rsp_err(rsp_err[0]),
        .o_vrb_rsp_rdata(rsp_rdata[0])
    );

    vrb_ram_slave #(.LATENCY(3)) u_lat3 (
        .clk(clk), .rst(rst),
        .i_vrb_cmd_valid(cmd_valid[1]), .i_vrb_cmd_addr(cmd_addr[1]),
        .i_vrb_cmd_read(cmd_read[1]), .i_vrb_cmd_wdata(cmd_wdata[1]),
        .i_vrb_cmd_wmask(cmd_wmask[1]),
        .o_vrb_rsp_valid(rsp_valid[1]), .o_vrb_rsp_err(rsp_err[1]),
        .o_vrb_rsp_rdata(rsp_rdata[1])
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        assert (got === want) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, got, want);
    endtask

    // Push the expected response and present a command at the next falling edge.
    task automatic issue(input int s, input logic [31:0] addr, input logic rd,
                         input logic [31:0] wd, input logic [3:0] wm,
                         input logic e_err, input logic [31:0] e_rdata);
        exp_t e;
        e.err   = e_err;
        e.rdata = e_rdata;
        sb.push_back(e);
        @(negedge clk);
        cmd_valid[s] = 1'b1;
        cmd_addr[s]  = addr;
        cmd_read[s]  = rd;
        cmd_wdata[s] = wd;
        cmd_wmask[s] = wm;
    endtask

    // Wait (bounded) for rsp_valid, then check latency and the scoreboard entry.
    task automatic await_rsp(input int s, input string tag, input int exp_lat);
        int   lat;
        bit   seen;
        exp_t e;
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid[s] === 1'b1) seen = 1'b1;
        end
        e = sb.pop_front();
        if (!seen) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
            chk({tag, "_err"}, 32'(rsp_err[s]), 32'(e.err));
            chk({tag, "_rdata"}, rsp_rdata[s], e.rdata);
        end
    endtask

    // Full transaction: issue, await, release, confirm a one-cycle strobe.
    task automatic xact(input int s, input string tag, input logic [31:0] addr,
                        input logic rd, input logic [31:0] wd, input logic [3:0] wm,
                        input logic e_err, input logic [31:0] e_rdata);
        issue(s, addr, rd, wd, wm, e_err, e_rdata);
        await_rsp(s, tag, (s == 0) ? 1 : 4);
        cmd_valid[s] = 1'b0;
        @(negedge clk);
        chk({tag, "_width"}, 32'(rsp_valid[s]), 32'd0);
        chk({tag, "_idle_out"}, rsp_rdata[s] | 32'(rsp_err[s]), 32'd0);
    endtask

    initial begin
        int any_rsp;
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            cmd_valid[s] = 1'b0;
            cmd_addr[s]  = '0;
            cmd_read[s]  = 1'b0;
            cmd_wdata[s] = '0;
            cmd_wmask[s] = '0;
        end
        repeat (2) @(negedge clk);
        chk("reset_valid0", 32'(rsp_valid[0]), 32'd0);
        chk("reset_valid3", 32'(rsp_valid[1]), 32'd0);
        chk("reset_out0", rsp_rdata[0] | 32'(rsp_err[0]), 32'd0);
        chk("reset_out3", rsp_rdata[1] | 32'(rsp_err[1]), 32'd0);
        rst = 1'b0;

        // Word store/load, LATENCY=0
        xact(0, "sw_word",  32'h2000_0004, 1'b0, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0);
        xact(0, "lw_word",  32'h2000_0004, 1'b1, 32'h0,         4'h0, 1'b0, 32'hDEAD_BEEF);

        // Byte store into upper lane
        xact(0, "sw_base4", 32'h2000_0004, 1'b0, 32'h1122_3344, 4'hF, 1'b0, 32'h0);
        xact(0, "sb_lane3", 32'h2000_0007, 1'b0, 32'hAA00_0000, 4'h8, 1'b0, 32'h0);
        xact(0, "lw_sb",    32'h2000_0004, 1'b1, 32'h0,         4'h0, 1'b0, 32'hAA22_3344);
        xact(0, "lw_unal",  32'h2000_0006, 1'b1, 32'h0,         4'h0, 1'b0, 32'hAA22_3344);

        // Halfword stores and illegal mask shapes
        xact(0, "sw_base0", 32'h2000_0000, 1'b0, 32'h1122_3344, 4'hF, 1'b0, 32'h0);
        xact(0, "sh_upper", 32'h2000_0002, 1'b0, 32'h5566_0000, 4'hC, 1'b0, 32'h0);
        xact(0, "lw_sh",    32'h2000_0000, 1'b1, 32'h0,         4'h0, 1'b0, 32'h5566_3344);
        xact(0, "sb_odd8",  32'h2000_0003, 1'b0, 32'h7700_0000, 4'h8, 1'b0, 32'h0);
        xact(0, "mask6",    32'h2000_0000, 1'b0, 32'hFFFF_FFFF, 4'h6, 1'b1, 32'h0);
        xact(0, "mask0",    32'h2000_0000, 1'b0, 32'hFFFF_FFFF, 4'h0, 1'b1, 32'h0);
        xact(0, "sh_odd3",  32'h2000_0001, 1'b0, 32'hFFFF_FFFF, 4'h3, 1'b1, 32'h0);
        xact(0, "sh_oddC",  32'h2000_0003, 1'b0, 32'hFFFF_FFFF, 4'hC, 1'b1, 32'h0);
        xact(0, "sw_misal", 32'h2000_0002, 1'b0, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0);
        xact(0, "lw_kept",  32'h2000_0000, 1'b1, 32'h0,         4'h0, 1'b0, 32'h7766_3344);

        // Range boundaries
        xact(0, "sw_last",  32'h2000_0FFC, 1'b0, 32'h0BAD_F00D, 4'hF, 1'b0, 32'h0);
        xact(0, "lw_last",  32'h2000_0FFC, 1'b1, 32'h0,         4'h0, 1'b0, 32'h0BAD_F00D);
        xact(0, "lw_past",  32'h2000_1000, 1'b1, 32'h0,         4'h0, 1'b1, 32'h0);
        xact(0, "lw_below", 32'h1FFF_FFFC, 1'b1, 32'h0,         4'h0, 1'b1, 32'h0);
        xact(0, "sw_past",  32'h2000_1000, 1'b0, 32'h1234_5678, 4'hF, 1'b1, 32'h0);

        // LATENCY=3 instance: latency, errors through the captured path
        xact(1, "l3_sw",    32'h2000_0010, 1'b0, 32'h1111_1111, 4'hF, 1'b0, 32'h0);
        xact(1, "l3_lw",    32'h2000_0010, 1'b1, 32'h0,         4'h0, 1'b0, 32'h1111_1111);
        xact(1, "l3_past",  32'h2000_1000, 1'b1, 32'h0,         4'h0, 1'b1, 32'h0);
        xact(1, "l3_mask6", 32'h2000_0010, 1'b0, 32'hFFFF_FFFF, 4'h6, 1'b1, 32'h0);

        // Back-to-back: second command follows the first response with no bubble
        issue(1, 32'h2000_0100, 1'b0, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0);
        await_rsp(1, "b2b_a", 4);
        begin
            exp_t e;
            e.err   = 1'b0;
            e.rdata = 32'hCAFE_F00D;
            sb.push_back(e);
        end
        cmd_addr[1] = 32'h2000_0100;
        cmd_read[1] = 1'b1;
        cmd_wmask[1] = 4'h0;
        await_rsp(1, "b2b_b", 5);
        cmd_valid[1] = 1'b0;
        @(negedge clk);
        chk("b2b_width", 32'(rsp_valid[1]), 32'd0);

        // Reset while a store waits: nothing commits, no response
        @(negedge clk);
        cmd_valid[1] = 1'b1;
        cmd_addr[1]  = 32'h2000_0010;
        cmd_read[1]  = 1'b0;
        cmd_wdata[1] = 32'h2222_2222;
        cmd_wmask[1] = 4'hF;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        cmd_valid[1] = 1'b0;
        #1;
        chk("rst_wait_valid", 32'(rsp_valid[1]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        any_rsp = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid[1] === 1'b1) any_rsp++;
        end
        chk("rst_wait_norsp", 32'(any_rsp), 32'd0);
        xact(1, "rst_old",  32'h2000_0010, 1'b1, 32'h0, 4'h0, 1'b0, 32'h1111_1111);

        // Reset during RESP drops the strobe immediately
        issue(1, 32'h2000_0010, 1'b1, 32'h0, 4'h0, 1'b0, 32'h1111_1111);
        await_rsp(1, "rst_resp", 4);
        rst = 1'b1;
        #1;
        chk("rst_resp_valid", 32'(rsp_valid[1]), 32'd0);
        chk("rst_resp_rdata", rsp_rdata[1], 32'd0);
        cmd_valid[1] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
